// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state encodings,
// default geometry and small address helpers.
package icache_pkg;

   localparam int ICACHE_INDEX_BITS = 7;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic {
      ICACHE_IDLE = 1'b0,
      ICACHE_MISS = 1'b1
   } icache_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_array.sv
// Tag and data storage for the instruction cache: one asynchronous read port,
// one synchronous write port. Contents are intentionally not reset.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   // Line write on refill completion
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_tag  = tag_mem[rd_index];
   assign rd_data = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with a two-state refill FSM.
// Optional statistics counters are built only when ICACHE_STATS_EN is defined.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        jump_or_not_in,
   input  logic        if_enable_in,
   input  logic [31:0] if_address_in,
   output logic [31:0] inst_out,
   output logic        inst_valid_out,
   output logic        mem_inst_enable_out,
   output logic [31:0] mem_inst_address_out,
   input  logic [31:0] mem_inst_data_in,
   input  logic        mem_inst_valid_in,
   output logic [31:0] hit_count_out,
   output logic [31:0] miss_count_out
);

   localparam int LINES = 1 << INDEX_BITS;

   icache_state_t         state_r;
   icache_state_t         state_nxt_s;
   logic [LINES-1:0]      valid_r;

   logic [INDEX_BITS-1:0] rd_index_s;
   logic [TAG_BITS-1:0]   req_tag_s;
   logic [TAG_BITS-1:0]   rd_tag_s;
   logic [31:0]           rd_data_s;
   logic [INDEX_BITS-1:0] wr_index_s;
   logic [TAG_BITS-1:0]   wr_tag_s;

   logic                  accept_s;
   logic                  hit_s;
   logic                  miss_s;
   logic                  fill_s;
   logic                  addr_unused_s;

   logic [31:0]           inst_nxt_s;
   logic                  inst_valid_nxt_s;
   logic                  mem_en_nxt_s;
   logic [31:0]           mem_addr_nxt_s;

   assign rd_index_s    = if_address_in[INDEX_BITS+1:2];
   assign req_tag_s     = if_address_in[31:2+INDEX_BITS];
   assign addr_unused_s = ^if_address_in[1:0];

   // The refill target is the registered request address, which stays frozen in MISS
   assign wr_index_s = mem_inst_address_out[INDEX_BITS+1:2];
   assign wr_tag_s   = mem_inst_address_out[31:2+INDEX_BITS];

   assign accept_s = (state_r == ICACHE_IDLE) && if_enable_in && !jump_or_not_in;
   assign hit_s    = accept_s && valid_r[rd_index_s] && (rd_tag_s == req_tag_s);
   assign miss_s   = accept_s && !hit_s;
   assign fill_s   = (state_r == ICACHE_MISS) && mem_inst_valid_in && !jump_or_not_in;

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk      (clk_in),
      .rd_index (rd_index_s),
      .rd_tag   (rd_tag_s),
      .rd_data  (rd_data_s),
      .wr_en    (fill_s),
      .wr_index (wr_index_s),
      .wr_tag   (wr_tag_s),
      .wr_data  (mem_inst_data_in)
   );

   // FSM state register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r <= ICACHE_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a redirect always wins over a completing refill
   always_comb begin
      state_nxt_s = ICACHE_IDLE;
      case (state_r)
         ICACHE_IDLE: begin
            if (miss_s) begin
               state_nxt_s = ICACHE_MISS;
            end else begin
               state_nxt_s = ICACHE_IDLE;
            end
         end
         ICACHE_MISS: begin
            if (jump_or_not_in || mem_inst_valid_in) begin
               state_nxt_s = ICACHE_IDLE;
            end else begin
               state_nxt_s = ICACHE_MISS;
            end
         end
         default: state_nxt_s = ICACHE_IDLE;
      endcase
   end

   // FSM output logic: next values for the registered outputs
   always_comb begin
      inst_nxt_s       = inst_out;
      inst_valid_nxt_s = 1'b0;
      mem_en_nxt_s     = mem_inst_enable_out;
      mem_addr_nxt_s   = mem_inst_address_out;
      case (state_r)
         ICACHE_IDLE: begin
            if (hit_s) begin
               inst_nxt_s       = rd_data_s;
               inst_valid_nxt_s = 1'b1;
               mem_en_nxt_s     = 1'b0;
            end else if (miss_s) begin
               mem_en_nxt_s   = 1'b1;
               mem_addr_nxt_s = word_align(if_address_in);
            end else begin
               mem_en_nxt_s = 1'b0;
            end
         end
         ICACHE_MISS: begin
            if (jump_or_not_in) begin
               mem_en_nxt_s = 1'b0;
            end else if (mem_inst_valid_in) begin
               inst_nxt_s       = mem_inst_data_in;
               inst_valid_nxt_s = 1'b1;
               mem_en_nxt_s     = 1'b0;
            end else begin
               mem_en_nxt_s = 1'b1;
            end
         end
         default: begin
            mem_en_nxt_s = 1'b0;
         end
      endcase
   end

   // Output registers and per-line valid bits
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         inst_out             <= ZERO_WORD;
         inst_valid_out       <= 1'b0;
         mem_inst_enable_out  <= 1'b0;
         mem_inst_address_out <= ZERO_WORD;
         valid_r              <= '0;
      end else begin
         inst_out             <= inst_nxt_s;
         inst_valid_out       <= inst_valid_nxt_s;
         mem_inst_enable_out  <= mem_en_nxt_s;
         mem_inst_address_out <= mem_addr_nxt_s;
         if (fill_s) begin
            valid_r[wr_index_s] <= 1'b1;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   // Hit/miss statistics, wrapping naturally at 32 bits
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         hit_count_out  <= 32'd0;
         miss_count_out <= 32'd0;
      end else begin
         if (hit_s) begin
            hit_count_out <= hit_count_out + 32'd1;
         end
         if (miss_s) begin
            miss_count_out <= miss_count_out + 32'd1;
         end
      end
   end
`else
   assign hit_count_out  = 32'd0;
   assign miss_count_out = 32'd0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache; counter expectations follow ICACHE_STATS_EN.
module tb_icache;

`ifdef ICACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        jump_or_not_in = 1'b0;
   logic        if_enable_in = 1'b0;
   logic [31:0] if_address_in = 32'h0;
   logic [31:0] inst_out;
   logic        inst_valid_out;
   logic        mem_inst_enable_out;
   logic [31:0] mem_inst_address_out;
   logic [31:0] mem_inst_data_in = 32'h0;
   logic        mem_inst_valid_in = 1'b0;
   logic [31:0] hit_count_out;
   logic [31:0] miss_count_out;

   int errors = 0;
   int checks = 0;

   icache dut (
      .clk_in               (clk_in),
      .rst_in               (rst_in),
      .jump_or_not_in       (jump_or_not_in),
      .if_enable_in         (if_enable_in),
      .if_address_in        (if_address_in),
      .inst_out             (inst_out),
      .inst_valid_out       (inst_valid_out),
      .mem_inst_enable_out  (mem_inst_enable_out),
      .mem_inst_address_out (mem_inst_address_out),
      .mem_inst_data_in     (mem_inst_data_in),
      .mem_inst_valid_in    (mem_inst_valid_in),
      .hit_count_out        (hit_count_out),
      .miss_count_out       (miss_count_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] scl(input int n);
      return STATS ? n : 0;
   endfunction

   // Present a request for one cycle; returns #1 after the sampling edge
   task automatic issue(input logic [31:0] a);
      if_enable_in  = 1'b1;
      if_address_in = a;
      @(posedge clk_in); #1;
      if_enable_in  = 1'b0;
      if_address_in = $urandom;
   endtask

   // Hold the miss for n cycles with junk requests; report whether the refill request stayed stable
   task automatic hold_miss(input int n, input logic [31:0] exp_addr, output bit stable);
      stable = 1'b1;
      for (int i = 0; i < n; i++) begin
         if_enable_in  = 1'b1;
         if_address_in = $urandom;
         mem_inst_data_in = $urandom;
         @(posedge clk_in); #1;
         if (mem_inst_enable_out !== 1'b1 || mem_inst_address_out !== exp_addr) stable = 1'b0;
      end
      if_enable_in = 1'b0;
   endtask

   // Memory returns refill data for one cycle
   task automatic complete(input logic [31:0] d);
      mem_inst_valid_in = 1'b1;
      mem_inst_data_in  = d;
      @(posedge clk_in); #1;
      mem_inst_valid_in = 1'b0;
      mem_inst_data_in  = $urandom;
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      checks += 5;
      if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_out); end
      if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_out); end
      if (mem_inst_enable_out !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_inst_enable_out); end
      if (mem_inst_address_out !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_inst_address_out); end
      if (hit_count_out !== 32'h0 || miss_count_out !== 32'h0) begin
         errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_count_out, miss_count_out);
      end
      rst_in = 1'b1;
   endtask

   task automatic test_cold_miss();
      bit stable;
      issue(32'h0000_0010);
      checks += 3;
      if (mem_inst_enable_out !== 1'b1) begin errors++; $display("FAIL cold_req: got %b expected 1", mem_inst_enable_out); end
      if (mem_inst_address_out !== 32'h0000_0010) begin errors++; $display("FAIL cold_addr: got %h expected 00000010", mem_inst_address_out); end
      if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL cold_early_valid: got %b expected 0", inst_valid_out); end
      hold_miss(4, 32'h0000_0010, stable);
      checks++;
      if (!stable) begin errors++; $display("FAIL cold_req_stable: got unstable expected stable"); end
      complete(32'h0050_0093);
      checks += 3;
      if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL cold_valid: got %b expected 1", inst_valid_out); end
      if (inst_out !== 32'h0050_0093) begin errors++; $display("FAIL cold_inst: got %h expected 00500093", inst_out); end
      if (mem_inst_enable_out !== 1'b0) begin errors++; $display("FAIL cold_req_drop: got %b expected 0", mem_inst_enable_out); end
      @(posedge clk_in); #1;
      checks++;
      if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL cold_pulse_width: got %b expected 0", inst_valid_out); end
   endtask

   task automatic test_hit();
      issue(32'h0000_0010);
      checks += 4;
      if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL hit_valid: got %b expected 1", inst_valid_out); end
      if (inst_out !== 32'h0050_0093) begin errors++; $display("FAIL hit_inst: got %h expected 00500093", inst_out); end
      if (mem_inst_enable_out !== 1'b0) begin errors++; $display("FAIL hit_no_req: got %b expected 0", mem_inst_enable_out); end
      if (hit_count_out !== scl(1) || miss_count_out !== scl(1)) begin
         errors++; $display("FAIL hit_counts: got %0d/%0d expected %0d/%0d", hit_count_out, miss_count_out, scl(1), scl(1));
      end
   endtask

   task automatic test_back_to_back();
      bit stable;
      logic [31:0] addrs [3];
      logic [31:0] datas [3];
      addrs = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0010};
      datas = '{32'h0050_0093, 32'h00A0_0113, 32'h0050_0093};
      issue(32'h0000_0014);
      hold_miss(1, 32'h0000_0014, stable);
      complete(32'h00A0_0113);
      for (int i = 0; i < 3; i++) begin
         if_enable_in  = 1'b1;
         if_address_in = addrs[i];
         @(posedge clk_in); #1;
         checks++;
         if (inst_valid_out !== 1'b1 || inst_out !== datas[i]) begin
            errors++; $display("FAIL b2b_hit%0d: got %b/%h expected 1/%h", i, inst_valid_out, inst_out, datas[i]);
         end
      end
      if_enable_in = 1'b0;
      checks++;
      if (hit_count_out !== scl(4) || miss_count_out !== scl(2)) begin
         errors++; $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d", hit_count_out, miss_count_out, scl(4), scl(2));
      end
   endtask

   task automatic test_conflict();
      bit stable;
      issue(32'h0000_0210);
      checks += 2;
      if (mem_inst_enable_out !== 1'b1 || mem_inst_address_out !== 32'h0000_0210) begin
         errors++; $display("FAIL conflict_req: got %b/%h expected 1/00000210", mem_inst_enable_out, mem_inst_address_out);
      end
      hold_miss(2, 32'h0000_0210, stable);
      complete(32'hDEAD_BEEF);
      if (inst_valid_out !== 1'b1 || inst_out !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL conflict_fill: got %b/%h expected 1/deadbeef", inst_valid_out, inst_out);
      end
      issue(32'h0000_0010);
      checks += 2;
      if (mem_inst_enable_out !== 1'b1 || inst_valid_out !== 1'b0) begin
         errors++; $display("FAIL conflict_evicted: got req=%b valid=%b expected req=1 valid=0", mem_inst_enable_out, inst_valid_out);
      end
      complete(32'h0050_0093);
      if (inst_out !== 32'h0050_0093 || miss_count_out !== scl(4)) begin
         errors++; $display("FAIL conflict_refill: got %h/%0d expected 00500093/%0d", inst_out, miss_count_out, scl(4));
      end
   endtask

   task automatic test_jump_mid_miss();
      bit stable;
      issue(32'h0000_0040);
      hold_miss(2, 32'h0000_0040, stable);
      jump_or_not_in = 1'b1;
      @(posedge clk_in); #1;
      jump_or_not_in = 1'b0;
      checks += 2;
      if (mem_inst_enable_out !== 1'b0) begin errors++; $display("FAIL jump_req_drop: got %b expected 0", mem_inst_enable_out); end
      if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL jump_no_valid: got %b expected 0", inst_valid_out); end
      @(posedge clk_in); #1;
      issue(32'h0000_0040);
      checks++;
      if (mem_inst_enable_out !== 1'b1 || inst_valid_out !== 1'b0) begin
         errors++; $display("FAIL jump_line_invalid: got req=%b valid=%b expected req=1 valid=0", mem_inst_enable_out, inst_valid_out);
      end
      complete(32'h1111_1111);
      // A request presented together with a redirect must be dropped, even for a resident line
      if_enable_in   = 1'b1;
      if_address_in  = 32'h0000_0010;
      jump_or_not_in = 1'b1;
      @(posedge clk_in); #1;
      if_enable_in   = 1'b0;
      jump_or_not_in = 1'b0;
      checks += 2;
      if (inst_valid_out !== 1'b0 || mem_inst_enable_out !== 1'b0) begin
         errors++; $display("FAIL jump_reject: got valid=%b req=%b expected 0/0", inst_valid_out, mem_inst_enable_out);
      end
      if (hit_count_out !== scl(4) || miss_count_out !== scl(6)) begin
         errors++; $display("FAIL jump_counts: got %0d/%0d expected %0d/%0d", hit_count_out, miss_count_out, scl(4), scl(6));
      end
   endtask

   task automatic test_jump_with_valid();
      bit stable;
      issue(32'h0000_0080);
      hold_miss(1, 32'h0000_0080, stable);
      jump_or_not_in    = 1'b1;
      mem_inst_valid_in = 1'b1;
      mem_inst_data_in  = 32'h2222_2222;
      @(posedge clk_in); #1;
      jump_or_not_in    = 1'b0;
      mem_inst_valid_in = 1'b0;
      checks++;
      if (inst_valid_out !== 1'b0 || mem_inst_enable_out !== 1'b0) begin
         errors++; $display("FAIL jumpvalid_suppress: got valid=%b req=%b expected 0/0", inst_valid_out, mem_inst_enable_out);
      end
      issue(32'h0000_0080);
      checks++;
      if (mem_inst_enable_out !== 1'b1 || inst_valid_out !== 1'b0) begin
         errors++; $display("FAIL jumpvalid_no_write: got req=%b valid=%b expected req=1 valid=0", mem_inst_enable_out, inst_valid_out);
      end
      complete(32'h3333_3333);
      checks++;
      if (inst_out !== 32'h3333_3333 || miss_count_out !== scl(8)) begin
         errors++; $display("FAIL jumpvalid_refill: got %h/%0d expected 33333333/%0d", inst_out, miss_count_out, scl(8));
      end
   endtask

   task automatic test_async_reset();
      bit stable;
      issue(32'h0000_0210);
      hold_miss(1, 32'h0000_0210, stable);
      #3;
      rst_in = 1'b0;
      #1;
      checks += 3;
      if (mem_inst_enable_out !== 1'b0 || mem_inst_address_out !== 32'h0) begin
         errors++; $display("FAIL areset_req: got %b/%h expected 0/00000000", mem_inst_enable_out, mem_inst_address_out);
      end
      if (inst_valid_out !== 1'b0 || inst_out !== 32'h0) begin
         errors++; $display("FAIL areset_inst: got %b/%h expected 0/00000000", inst_valid_out, inst_out);
      end
      if (hit_count_out !== 32'h0 || miss_count_out !== 32'h0) begin
         errors++; $display("FAIL areset_counts: got %0d/%0d expected 0/0", hit_count_out, miss_count_out);
      end
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      issue(32'h0000_0010);
      checks++;
      if (mem_inst_enable_out !== 1'b1 || inst_valid_out !== 1'b0) begin
         errors++; $display("FAIL areset_refetch_miss: got req=%b valid=%b expected req=1 valid=0", mem_inst_enable_out, inst_valid_out);
      end
      complete(32'h0050_0093);
      checks++;
      if (inst_valid_out !== 1'b1 || hit_count_out !== scl(0) || miss_count_out !== scl(1)) begin
         errors++; $display("FAIL areset_refill: got valid=%b %0d/%0d expected 1 %0d/%0d",
                            inst_valid_out, hit_count_out, miss_count_out, scl(0), scl(1));
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_back_to_back();
      test_conflict();
      test_jump_mid_miss();
      test_jump_with_valid();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have parameter INDEX_BITS, default 7, meaning 2^INDEX_BITS direct-mapped lines of one 32-bit word each.
REQ-002 The module SHALL have parameter TAG_BITS, default 30-INDEX_BITS, meaning the tag width taken from address[31:2+INDEX_BITS].
REQ-003 The module SHALL have port clk_in, input, 1, the single clock, rising edge.
REQ-004 The module SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port jump_or_not_in, input, 1, pipeline redirect that aborts the current fetch.
REQ-006 The module SHALL have port if_enable_in, input, 1, fetch request from the IF stage.
REQ-007 The module SHALL have port if_address_in, input, 32, fetch PC; bits [1:0] are ignored.
REQ-008 The module SHALL have port inst_out, output, 32, fetched instruction.
REQ-009 The module SHALL have port inst_valid_out, output, 1, one-cycle pulse qualifying inst_out.
REQ-010 The module SHALL have port mem_inst_enable_out, output, 1, refill request to memory_control (its inst_enable_in).
REQ-011 The module SHALL have port mem_inst_address_out, output, 32, refill word address with bits [1:0]=0.
REQ-012 The module SHALL have port mem_inst_data_in, input, 32, refill data (memory_control inst_data_out).
REQ-013 The module SHALL have port mem_inst_valid_in, input, 1, refill-done pulse (memory_control inst_enable_out).
REQ-014 The module SHALL have ports hit_count_out and miss_count_out, output, 32 each, statistics counters.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and MISS, encoded 1'b0 and 1'b1.
REQ-016 In IDLE, when if_enable_in=1 and jump_or_not_in=0, the block SHALL sample the address on the clock edge and look up line address[INDEX_BITS+1:2].
REQ-017 A lookup is a hit when the line's valid bit is 1 and its stored tag equals address[31:2+INDEX_BITS]; on a hit the block SHALL drive inst_out and a 1-cycle inst_valid_out in the cycle after sampling, and stay in IDLE.
REQ-018 On a miss the block SHALL enter MISS and hold mem_inst_enable_out=1 and mem_inst_address_out={addr[31:2],2'b00} constant until mem_inst_valid_in=1.
REQ-019 On the edge where mem_inst_valid_in=1 in MISS, the block SHALL write data, tag and valid=1 into the line, drive inst_out=mem_inst_data_in and inst_valid_out=1 in the next cycle, drop mem_inst_enable_out, and return to IDLE.
REQ-020 In MISS, if_enable_in and if_address_in SHALL be ignored; the fill completes for the originally sampled address.
REQ-021 When jump_or_not_in=1, the block SHALL return to IDLE, deassert mem_inst_enable_out, suppress inst_valid_out in the next cycle, and skip the line write even if mem_inst_valid_in=1 in the same cycle.
REQ-022 A request in a cycle with jump_or_not_in=1 SHALL NOT be accepted.
REQ-023 Hit latency SHALL be 1 cycle; miss latency SHALL be (memory_control refill cycles)+1.
REQ-024 Back-to-back hits SHALL be accepted on consecutive cycles at a throughput of 1 per cycle.
REQ-025 hit_count_out and miss_count_out SHALL increment by 1 per accepted hit and per accepted miss respectively, wrapping modulo 2^32.

Reset
REQ-026 While rst_in=0 (asynchronous), the state SHALL be IDLE and all valid bits, inst_out, inst_valid_out, mem_inst_enable_out, mem_inst_address_out and both counters SHALL be 0.
REQ-027 Tag and data arrays SHALL NOT be reset.
REQ-028 Reset during MISS SHALL abandon the refill with no line written.

Configuration
REQ-029 With ICACHE_STATS_EN defined, hit_count_out and miss_count_out SHALL be live counters.
REQ-030 Without ICACHE_STATS_EN, both ports SHALL exist, be tied to 0, and no counter flops SHALL be built.

Structure
REQ-031 The shared Defines.v SHALL hold the state encodings ICACHE_IDLE/ICACHE_MISS and the default ICACHE_INDEX_BITS, alongside the existing regbus/InstAddrBus/zeroword defines.
REQ-032 The design SHALL use one sub-module, icache_array, holding the data and tag arrays, with 1 asynchronous read port and 1 synchronous write port; valid bits SHALL remain in icache as a resettable flop vector.

Verification
REQ-033 Cold miss: after reset, fetch 0x00000010 with memory returning 0x00500093 after 5 cycles -> one mem request at 0x00000010, inst_out=0x00500093 with inst_valid_out for exactly 1 cycle.
REQ-034 Hit: refetch 0x00000010 -> inst_valid_out 1 cycle after request, no mem_inst_enable_out, hit_count_out=1.
REQ-035 Conflict: fetch 0x00000210 (same index, INDEX_BITS=7) -> miss, line replaced; next fetch of 0x00000010 misses again.
REQ-036 Jump mid-miss: jump_or_not_in=1 on refill cycle 3 -> request drops next cycle, no inst_valid_out, line stays invalid, later fetch misses.
REQ-037 Jump coincident with mem_inst_valid_in -> no write, no inst_valid_out.
REQ-038 Async reset asserted mid-MISS between clock edges -> outputs clear immediately; a subsequent fetch of 0x00000010 misses.
